// File: rtl/addsub_arbiter.sv
// Two-port round-robin arbiter in front of one shared 4-bit add/subtract unit.
// Each port runs req/gnt/done/ack; the registered result is held until the winner acknowledges it.

module add_sub (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       sub_i,
  output logic [3:0] sum_o,
  output logic       ovf_o
);
  // Ripple carry; subtraction is A + ~B + 1 with the +1 injected as carry-in.
  always_comb begin
    logic [4:0] c;
    logic       bx;
    c     = '0;
    bx    = 1'b0;
    sum_o = '0;
    c[0]  = sub_i;
    for (int i = 0; i < 4; i++) begin
      bx       = b_i[i] ^ sub_i;
      sum_o[i] = a_i[i] ^ bx ^ c[i];
      c[i+1]   = (a_i[i] & bx) | (a_i[i] & c[i]) | (bx & c[i]);
    end
    ovf_o = c[3] ^ c[4];
  end
endmodule

module addsub_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0,
  input  logic [3:0] OpA0,
  input  logic [3:0] OpB0,
  input  logic       OpSel0,
  input  logic       Ack0,
  output logic       Gnt0,
  output logic       Done0,
  input  logic       Req1,
  input  logic [3:0] OpA1,
  input  logic [3:0] OpB1,
  input  logic       OpSel1,
  input  logic       Ack1,
  output logic       Gnt1,
  output logic       Done1,
  output logic [3:0] Sum,
  output logic       Overflow,
  output logic       Busy,
  output logic [1:0] State
);
  // Handshake: a port's Req is sampled only in IDLE; Gnt pulses for the single EXEC
  // cycle; Done stays high through WAIT until the winner's Ack is seen on an edge.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WAIT = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       win_q, win_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       sel_q, sel_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic [3:0] sum_q, sum_d;
  logic       ovf_q, ovf_d;
  logic       busy_q, busy_d;

  logic [3:0] alu_sum;
  logic       alu_ovf;

  add_sub u_add_sub (
    .a_i   (a_q),
    .b_i   (b_q),
    .sub_i (sel_q),
    .sum_o (alu_sum),
    .ovf_o (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = done0_q;
    done1_d = done1_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          win_d   = (Req0 && Req1) ? ptr_q : Req1;
          a_d     = win_d ? OpA1 : OpA0;
          b_d     = win_d ? OpB1 : OpB0;
          sel_d   = win_d ? OpSel1 : OpSel0;
          gnt0_d  = ~win_d;
          gnt1_d  = win_d;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = alu_sum;
        ovf_d   = alu_ovf;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = ~win_q;
        done1_d = win_q;
        state_d = WAIT;
      end
      WAIT: begin
        if (win_q ? Ack1 : Ack0) begin
          done0_d = 1'b0;
          done1_d = 1'b0;
          busy_d  = 1'b0;
          ptr_d   = ~win_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= RR_INIT;
      win_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign Gnt0     = gnt0_q;
  assign Gnt1     = gnt1_q;
  assign Done0    = done0_q;
  assign Done1    = done1_q;
  assign Sum      = sum_q;
  assign Overflow = ovf_q;
  assign Busy     = busy_q;
  assign State    = state_q;
endmodule
